// File: rtl/addsub_pkg.sv
// Shared helpers for the pipelined add/subtract unit: saturation constants and a log2 helper.
package addsub_pkg;

    localparam int unsigned MAX_W = 64;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

    // Largest positive two's complement value of width w (0x7F..F).
    function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    // Most negative two's complement value of width w (0x80..0).
    function automatic logic [MAX_W-1:0] sat_min(input int unsigned w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// One SEG-bit ripple-carry slice of the pipelined adder.
// Also exposes the carry into its MSB so the top slice can flag signed overflow.
module addsub_seg
    import addsub_pkg::*;
#(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_cin,
    output logic [SEG-1:0] o_sum,
    output logic           o_cout,
    output logic           o_cim
);

    logic [SEG:0] w_c;

    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < int'(SEG); i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_c[SEG];
    assign o_cim  = w_c[SEG-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined signed/unsigned add/subtract with optional signed saturation.
// Carry chain is cut into STAGES registered slices; valid/ready stream with a global stall enable.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow,
    output logic             out_cbout
);

    localparam int unsigned SEG = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0 || WIDTH > MAX_W) begin : g_bad_cfg
        $error("addsub_pipe: need 1 <= STAGES <= WIDTH <= 64 and WIDTH a multiple of STAGES");
    end

    // In-flight beat: operands travel with the partial sum and the slice carry.
    typedef struct packed {
        logic             valid;
        logic             sub;
        logic             sat;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             carry;
    } stage_t;

    logic   w_adv;
    stage_t w_src [STAGES];

    // The whole pipe advances together; it only holds when the output beat is stuck.
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    // Subtraction is a + ~b + 1: invert b and inject the 1 as the first carry-in.
    assign w_src[0] = '{
        valid: in_valid,
        sub:   in_sub,
        sat:   in_sat,
        a:     in_a,
        b:     in_sub ? ~in_b : in_b,
        sum:   '0,
        carry: in_sub
    };

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        logic [SEG-1:0] w_sum;
        logic           w_cout;
        logic           w_cim;

        addsub_seg #(
            .SEG (SEG)
        ) u_seg (
            .i_a    (w_src[k].a[k*SEG +: SEG]),
            .i_b    (w_src[k].b[k*SEG +: SEG]),
            .i_cin  (w_src[k].carry),
            .o_sum  (w_sum),
            .o_cout (w_cout),
            .o_cim  (w_cim)
        );

        if (k < int'(STAGES) - 1) begin : g_mid
            stage_t w_nxt;
            stage_t r_stg;
            logic   w_unused_cim;

            assign w_unused_cim = w_cim;

            always_comb begin
                w_nxt                   = w_src[k];
                w_nxt.sum[k*SEG +: SEG] = w_sum;
                w_nxt.carry             = w_cout;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stg <= '0;
                end else if (w_adv) begin
                    r_stg <= w_nxt;
                end
            end

            assign w_src[k+1] = r_stg;
        end else begin : g_last
            logic [WIDTH-1:0] w_raw;
            logic             w_ovf;
            logic             w_clamp;

            always_comb begin
                w_raw                   = w_src[k].sum;
                w_raw[k*SEG +: SEG]     = w_sum;
            end

            assign w_ovf   = w_cout ^ w_cim;
            assign w_clamp = SAT_EN & w_src[k].sat & w_ovf;

            // Final slice writes straight into the output registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid    <= 1'b0;
                    out_result   <= '0;
                    out_overflow <= 1'b0;
                    out_cbout    <= 1'b0;
                end else if (w_adv) begin
                    out_valid <= w_src[k].valid;
                    if (w_src[k].valid) begin
                        out_result   <= w_clamp ? (w_src[k].a[WIDTH-1] ? SAT_MIN : SAT_MAX) : w_raw;
                        out_overflow <= w_ovf;
                        out_cbout    <= w_src[k].sub ? ~w_cout : w_cout;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe (WIDTH=16, STAGES=2, SAT_EN=1).
module tb_addsub_pipe;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_sat;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_overflow;
    logic         out_cbout;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          rdy_mode = 0;
    logic [3:0]  rdy_pat  = 4'b1001;
    logic [17:0] sb_q [$];

    addsub_pipe #(
        .WIDTH  (W),
        .STAGES (2),
        .SAT_EN (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .in_sat       (in_sat),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_cbout    (out_cbout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Golden model from integer arithmetic: {result, overflow, carry/borrow}.
    function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub, input logic sat);
        int sa, sb, sr, ua, ub, ur;
        logic ovf, cb;
        logic [W-1:0] res;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        ua  = int'(a);
        ub  = int'(b);
        sr  = sub ? sa - sb : sa + sb;
        ur  = sub ? ua - ub : ua + ub;
        ovf = (sr > 32767) || (sr < -32768);
        cb  = sub ? (ua < ub) : (ur > 65535);
        res = 16'(ur);
        if (sat && ovf) res = (sr > 0) ? 16'h7FFF : 16'h8000;
        return {res, ovf, cb};
    endfunction

    // One clock: drive at negedge, observe 1ns later, retire/accept at the following posedge.
    task automatic drive_cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub, input logic sat, input logic [17:0] exp,
                               output logic acc, output logic seen);
        logic ordy, exp_rdy;
        logic [17:0] e;
        case (rdy_mode)
            0:       ordy = 1'b1;
            1:       ordy = rdy_pat[cyc % 4];
            default: ordy = ($urandom_range(3) != 0);
        endcase
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_sat    = sat;
        out_ready = ordy;
        #1;
        seen    = out_valid;
        exp_rdy = !out_valid || ordy;
        check("in_ready", in_ready, exp_rdy);
        if (out_valid && ordy) begin
            check("sb_nonempty", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("result", out_result, e[17:2]);
                check("overflow", out_overflow, e[1]);
                check("cbout", out_cbout, e[0]);
            end
        end
        acc = v && in_ready;
        if (acc) sb_q.push_back(exp);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(output logic seen);
        logic acc;
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, acc, seen);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic sat, input logic [17:0] exp);
        logic acc, seen;
        int tries;
        tries = 0;
        do begin
            drive_cycle(1'b1, a, b, sub, sat, exp, acc, seen);
            tries++;
        end while (!acc && tries < 50);
        check("accepted", acc, 1);
    endtask

    task automatic send_m(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic sat);
        send(a, b, sub, sat, model(a, b, sub, sat));
    endtask

    task automatic drain();
        logic seen;
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            idle(seen);
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
        repeat (4) idle(seen);
    endtask

    initial begin
        logic acc, seen;
        int lat, stale;
        logic [W-1:0] corners [6];
        logic [W-1:0] a, b;
        corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_sub = 1'b0; in_sat = 1'b0; out_ready = 1'b0;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_overflow", out_overflow, 0);
        check("rst_out_cbout", out_cbout, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // First beat and latency
        rdy_mode = 0;
        drive_cycle(1'b1, 16'h0005, 16'h0003, 1'b1, 1'b0, {16'h0002, 1'b0, 1'b0}, acc, seen);
        check("accept_first", acc, 1);
        lat = 0;
        do begin
            idle(seen);
            lat++;
        end while (!seen && lat < 10);
        check("latency", lat, 2);

        // Overflow, saturation and carry/borrow corners
        send(16'h8000, 16'h0001, 1'b1, 1'b0, {16'h7FFF, 1'b1, 1'b0});
        send(16'h8000, 16'h0001, 1'b1, 1'b1, {16'h8000, 1'b1, 1'b0});
        send(16'h0000, 16'h0001, 1'b1, 1'b0, {16'hFFFF, 1'b0, 1'b1});
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b0});
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b0, 1'b1});
        drain();

        // Mixed stream under a 1,0,0,1 out_ready pattern
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            send_m(16'(i * 16'h2345 + 16'h7000), 16'(i * 16'h1111 + 16'h0F00), i[0], i[1]);
        end
        drain();

        // Reset with two beats in flight
        rdy_mode = 0;
        send_m(16'h1234, 16'h0101, 1'b0, 1'b0);
        send_m(16'h4321, 16'h0101, 1'b1, 1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_result", out_result, 0);
        check("midrst_in_ready", in_ready, 1);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            idle(seen);
            stale += int'(seen);
        end
        check("no_stale", stale, 0);

        // Random beats with bubbles and random back-pressure
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(4) == 0) begin
                idle(seen);
            end else begin
                a = ($urandom_range(3) == 0) ? corners[$urandom_range(5)] : 16'($urandom);
                b = ($urandom_range(3) == 0) ? corners[$urandom_range(5)] : 16'($urandom);
                send_m(a, b, 1'($urandom), 1'($urandom));
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
